// File: rtl/cpu_clk_en_ctrl_pkg.sv
// Shared definitions for the CPU clock-enable scheduler: state and
// command encodings plus the reset-time divide ratio.
package cpu_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_HALT = 2'b00,
        ST_RUN  = 2'b01,
        ST_STEP = 2'b10,
        ST_DONE = 2'b11
    } state_t;

    typedef enum logic [1:0] {
        OP_HALT = 2'b00,
        OP_RUN  = 2'b01,
        OP_STEP = 2'b10,
        OP_RSVD = 2'b11
    } op_t;

    localparam int unsigned DIV_DEFAULT = 6;

endpackage

// File: rtl/cpu_clk_en_ctrl_if.sv
// Host/debug command port and divide-ratio write port of the scheduler.
interface cpu_clk_en_ctrl_if #(
    parameter int unsigned DIV_W  = 8,
    parameter int unsigned STEP_W = 16
);

    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [STEP_W-1:0] cmd_steps;
    logic              cfg_valid;
    logic [DIV_W-1:0]  cfg_div;

    modport master (
        output cmd_valid, cmd_op, cmd_steps, cfg_valid, cfg_div,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_steps, cfg_valid, cfg_div,
        output cmd_ready
    );

endinterface

// File: rtl/cpu_clk_en_ctrl_prescaler.sv
// Period counter for the core clock enable. Holds the ratio in force and
// a pending ratio that is only taken over when the counter restarts at 0,
// so no period is ever truncated.
module clk_en_prescaler #(
    parameter int unsigned DIV_W       = 8,
    parameter int unsigned DIV_DEFAULT = cpu_ctrl_pkg::DIV_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             active,     // RUN or STEP: counter is running
    input  logic             restart,    // clear counter and take pending ratio
    input  logic             stop,       // clear counter without taking the ratio
    input  logic             cfg_valid,
    input  logic [DIV_W-1:0] cfg_div,
    output logic             en,
    output logic [DIV_W-1:0] div_cur
);

    logic [DIV_W-1:0] div_cnt;
    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] pend_div;
    logic             pend_v;
    logic [DIV_W-1:0] cfg_eff;
    logic [DIV_W-1:0] new_q;
    logic             apply;

    // A zero ratio behaves as 1; a same-cycle write beats the pending value.
    always_comb begin
        cfg_eff = (cfg_div == '0) ? DIV_W'(1) : cfg_div;
        en      = active && (div_cnt == div_q - DIV_W'(1));
        apply   = restart || en;
        new_q   = cfg_valid ? cfg_eff : (pend_v ? pend_div : div_q);
    end

    // Counter, ratio-in-force and pending-ratio registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt  <= '0;
            div_q    <= DIV_W'(DIV_DEFAULT);
            pend_div <= '0;
            pend_v   <= 1'b0;
        end else if (apply) begin
            div_cnt <= '0;
            div_q   <= new_q;
            pend_v  <= 1'b0;
        end else begin
            if (stop || !active)
                div_cnt <= '0;
            else
                div_cnt <= div_cnt + DIV_W'(1);
            if (cfg_valid) begin
                pend_div <= cfg_eff;
                pend_v   <= 1'b1;
            end
        end
    end

    assign div_cur = div_q;

endmodule

// File: rtl/cpu_clk_en_ctrl.sv
// Clock-enable scheduler for the processor core: HALT / RUN / STEP-N
// control of a one-cycle cpu_en pulse issued once every div_cur cycles.
module cpu_clk_en_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned DIV_W       = 8,
    parameter int unsigned DIV_DEFAULT = cpu_ctrl_pkg::DIV_DEFAULT,
    parameter int unsigned STEP_W      = 16,
    parameter int unsigned CNT_W       = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    cpu_clk_en_ctrl_if.slave      bus,
    output logic                  cpu_en,
    output logic [1:0]            state,
    output logic                  step_done,
    output logic [DIV_W-1:0]      div_cur,
    output logic [CNT_W-1:0]      en_count
);

    state_t            state_q, state_nx;
    logic [STEP_W-1:0] remaining, rem_nx;
    logic              acc, steps_nz, active, restart, stop;

    clk_en_prescaler #(
        .DIV_W       (DIV_W),
        .DIV_DEFAULT (DIV_DEFAULT)
    ) u_prescaler (
        .clk       (clk),
        .reset     (reset),
        .active    (active),
        .restart   (restart),
        .stop      (stop),
        .cfg_valid (bus.cfg_valid),
        .cfg_div   (bus.cfg_div),
        .en        (cpu_en),
        .div_cur   (div_cur)
    );

    assign active        = (state_q == ST_RUN) || (state_q == ST_STEP);
    assign bus.cmd_ready = (state_q != ST_DONE);
    assign step_done     = (state_q == ST_DONE);
    assign state         = state_q;
    assign acc           = bus.cmd_valid && bus.cmd_ready;
    assign steps_nz      = (bus.cmd_steps != '0);

    // Next-state, step reload and prescaler restart/stop decode.
    // A STEP of zero pulses goes straight to DONE from any state.
    always_comb begin
        state_nx = state_q;
        rem_nx   = remaining;
        restart  = 1'b0;
        stop     = 1'b0;
        unique case (state_q)
            ST_HALT: begin
                restart = 1'b1;
                if (acc) begin
                    case (op_t'(bus.cmd_op))
                        OP_RUN:  state_nx = ST_RUN;
                        OP_STEP: begin
                            state_nx = steps_nz ? ST_STEP : ST_DONE;
                            rem_nx   = bus.cmd_steps;
                        end
                        default: ;
                    endcase
                end
            end
            ST_RUN: begin
                if (acc) begin
                    case (op_t'(bus.cmd_op))
                        OP_HALT: begin
                            state_nx = ST_HALT;
                            stop     = 1'b1;
                        end
                        OP_STEP: begin
                            restart  = 1'b1;
                            state_nx = steps_nz ? ST_STEP : ST_DONE;
                            rem_nx   = bus.cmd_steps;
                        end
                        default: ;
                    endcase
                end
            end
            ST_STEP: begin
                if (acc && op_t'(bus.cmd_op) == OP_HALT) begin
                    state_nx = ST_HALT;
                    stop     = 1'b1;
                end else if (acc && op_t'(bus.cmd_op) == OP_RUN) begin
                    state_nx = ST_RUN;
                end else if (acc && op_t'(bus.cmd_op) == OP_STEP) begin
                    restart  = 1'b1;
                    state_nx = steps_nz ? ST_STEP : ST_DONE;
                    rem_nx   = bus.cmd_steps;
                end else if (cpu_en) begin
                    rem_nx = remaining - STEP_W'(1);
                    if (remaining == STEP_W'(1))
                        state_nx = ST_DONE;
                end
            end
            ST_DONE: state_nx = ST_HALT;
            default: state_nx = ST_HALT;
        endcase
    end

    // State, remaining-step and issued-enable counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_HALT;
            remaining <= '0;
            en_count  <= '0;
        end else begin
            state_q   <= state_nx;
            remaining <= rem_nx;
            if (cpu_en)
                en_count <= en_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_cpu_clk_en_ctrl.sv
// Self-checking bench for cpu_clk_en_ctrl: directed scenarios plus a
// randomized run against a countdown-based reference model.
module tb_cpu_clk_en_ctrl;

    localparam int unsigned DIV_W  = 8;
    localparam int unsigned STEP_W = 16;
    localparam int unsigned CNT_W  = 32;

    logic             clk = 1'b0;
    logic             reset;
    logic             cpu_en;
    logic [1:0]       state;
    logic             step_done;
    logic [DIV_W-1:0] div_cur;
    logic [CNT_W-1:0] en_count;

    int checks = 0;
    int errors = 0;

    // Reference model: mode 0 HALT, 1 RUN, 2 STEP, 3 DONE; m_wait counts the
    // cycles left in the current period, the pulse falls on the last one.
    int          m_mode, m_wait, m_ratio, m_pend, m_pend_v, m_rem;
    int unsigned m_count;

    always #5 clk = ~clk;

    cpu_clk_en_ctrl_if #(.DIV_W(DIV_W), .STEP_W(STEP_W)) bus ();

    cpu_clk_en_ctrl #(
        .DIV_W       (DIV_W),
        .DIV_DEFAULT (6),
        .STEP_W      (STEP_W),
        .CNT_W       (CNT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .cpu_en    (cpu_en),
        .state     (state),
        .step_done (step_done),
        .div_cur   (div_cur),
        .en_count  (en_count)
    );

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'b00;
        bus.cmd_steps = '0;
        bus.cfg_valid = 1'b0;
        bus.cfg_div   = '0;
    endtask

    task automatic do_reset;
        idle_inputs();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic send_cmd(input logic [1:0] op, input int steps);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_steps = STEP_W'(steps);
        tick();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic test_reset;
        do_reset();
        for (int c = 0; c < 3; c++) begin
            checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_state c%0d: got %0d want 0", c, state); end
            checks++; if (cpu_en !== 1'b0) begin errors++; $display("FAIL reset_cpu_en c%0d: got %0b want 0", c, cpu_en); end
            checks++; if (step_done !== 1'b0) begin errors++; $display("FAIL reset_step_done c%0d: got %0b want 0", c, step_done); end
            checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready c%0d: got %0b want 1", c, bus.cmd_ready); end
            checks++; if (div_cur !== 8'd6) begin errors++; $display("FAIL reset_div_cur c%0d: got %0d want 6", c, div_cur); end
            checks++; if (en_count !== 32'd0) begin errors++; $display("FAIL reset_en_count c%0d: got %0d want 0", c, en_count); end
            tick();
        end
    endtask

    task automatic test_run_default;
        do_reset();
        send_cmd(2'b01, 0);
        for (int c = 1; c <= 19; c++) begin
            if (c <= 18) begin
                checks++; if (cpu_en !== 1'(c % 6 == 0)) begin errors++; $display("FAIL run_default_en c%0d: got %0b want %0b", c, cpu_en, (c % 6 == 0)); end
                checks++; if (state !== 2'd1) begin errors++; $display("FAIL run_default_state c%0d: got %0d want 1", c, state); end
            end else begin
                checks++; if (en_count !== 32'd3) begin errors++; $display("FAIL run_default_count: got %0d want 3", en_count); end
            end
            tick();
        end
    endtask

    task automatic test_step_div3;
        do_reset();
        bus.cfg_valid = 1'b1;
        bus.cfg_div   = 8'd3;
        tick();
        bus.cfg_valid = 1'b0;
        checks++; if (div_cur !== 8'd3) begin errors++; $display("FAIL step3_div_cur: got %0d want 3", div_cur); end
        send_cmd(2'b10, 4);
        for (int c = 1; c <= 14; c++) begin
            logic [1:0] es;
            es = (c <= 12) ? 2'd2 : ((c == 13) ? 2'd3 : 2'd0);
            checks++; if (cpu_en !== 1'(c % 3 == 0 && c <= 12)) begin errors++; $display("FAIL step3_en c%0d: got %0b want %0b", c, cpu_en, (c % 3 == 0 && c <= 12)); end
            checks++; if (step_done !== 1'(c == 13)) begin errors++; $display("FAIL step3_done c%0d: got %0b want %0b", c, step_done, (c == 13)); end
            checks++; if (state !== es) begin errors++; $display("FAIL step3_state c%0d: got %0d want %0d", c, state, es); end
            checks++; if (bus.cmd_ready !== 1'(c != 13)) begin errors++; $display("FAIL step3_ready c%0d: got %0b want %0b", c, bus.cmd_ready, (c != 13)); end
            tick();
        end
        checks++; if (en_count !== 32'd4) begin errors++; $display("FAIL step3_count: got %0d want 4", en_count); end
    endtask

    task automatic test_ratio_change;
        do_reset();
        send_cmd(2'b01, 0);
        bus.cfg_div = 8'd2;
        for (int c = 1; c <= 18; c++) begin
            logic       ee;
            logic [7:0] ed;
            ee = (c == 6) || (c == 12) || (c > 12 && c % 2 == 0);
            ed = (c <= 12) ? 8'd6 : 8'd2;
            checks++; if (cpu_en !== ee) begin errors++; $display("FAIL ratio_en c%0d: got %0b want %0b", c, cpu_en, ee); end
            checks++; if (div_cur !== ed) begin errors++; $display("FAIL ratio_div_cur c%0d: got %0d want %0d", c, div_cur, ed); end
            bus.cfg_valid = (c == 9);
            tick();
        end
        checks++; if (en_count !== 32'd5) begin errors++; $display("FAIL ratio_count: got %0d want 5", en_count); end
    endtask

    task automatic test_div_zero;
        do_reset();
        bus.cfg_valid = 1'b1;
        bus.cfg_div   = 8'd0;
        tick();
        bus.cfg_valid = 1'b0;
        checks++; if (div_cur !== 8'd1) begin errors++; $display("FAIL div0_div_cur: got %0d want 1", div_cur); end
        send_cmd(2'b01, 0);
        for (int c = 1; c <= 6; c++) begin
            checks++; if (cpu_en !== 1'b1) begin errors++; $display("FAIL div0_en c%0d: got %0b want 1", c, cpu_en); end
            checks++; if (en_count !== CNT_W'(c - 1)) begin errors++; $display("FAIL div0_count c%0d: got %0d want %0d", c, en_count, c - 1); end
            tick();
        end
    endtask

    task automatic test_step_zero;
        do_reset();
        send_cmd(2'b10, 0);
        checks++; if (state !== 2'd3) begin errors++; $display("FAIL step0_state: got %0d want 3", state); end
        checks++; if (step_done !== 1'b1) begin errors++; $display("FAIL step0_done: got %0b want 1", step_done); end
        checks++; if (cpu_en !== 1'b0) begin errors++; $display("FAIL step0_en: got %0b want 0", cpu_en); end
        checks++; if (bus.cmd_ready !== 1'b0) begin errors++; $display("FAIL step0_ready: got %0b want 0", bus.cmd_ready); end
        tick();
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL step0_back_state: got %0d want 0", state); end
        checks++; if (step_done !== 1'b0) begin errors++; $display("FAIL step0_back_done: got %0b want 0", step_done); end
        checks++; if (en_count !== 32'd0) begin errors++; $display("FAIL step0_count: got %0d want 0", en_count); end
    endtask

    task automatic test_step_halt;
        do_reset();
        send_cmd(2'b10, 5);
        bus.cmd_op = 2'b00;
        for (int c = 1; c <= 30; c++) begin
            checks++; if (cpu_en !== 1'(c == 6 || c == 12)) begin errors++; $display("FAIL stephalt_en c%0d: got %0b want %0b", c, cpu_en, (c == 6 || c == 12)); end
            checks++; if (step_done !== 1'b0) begin errors++; $display("FAIL stephalt_done c%0d: got %0b want 0", c, step_done); end
            checks++; if (state !== ((c <= 13) ? 2'd2 : 2'd0)) begin errors++; $display("FAIL stephalt_state c%0d: got %0d want %0d", c, state, (c <= 13) ? 2 : 0); end
            bus.cmd_valid = (c == 13);
            tick();
        end
        bus.cmd_valid = 1'b0;
        checks++; if (en_count !== 32'd2) begin errors++; $display("FAIL stephalt_count: got %0d want 2", en_count); end
    endtask

    task automatic test_reset_mid_step;
        do_reset();
        send_cmd(2'b10, 10);
        bus.cfg_div = 8'd4;
        for (int c = 1; c <= 8; c++) begin
            bus.cfg_valid = (c == 8);
            tick();
        end
        bus.cfg_valid = 1'b0;
        checks++; if (en_count !== 32'd1) begin errors++; $display("FAIL midrst_pre_count: got %0d want 1", en_count); end
        reset = 1'b1;
        #1;
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL midrst_state: got %0d want 0", state); end
        checks++; if (div_cur !== 8'd6) begin errors++; $display("FAIL midrst_div_cur: got %0d want 6", div_cur); end
        checks++; if (en_count !== 32'd0) begin errors++; $display("FAIL midrst_count: got %0d want 0", en_count); end
        checks++; if (cpu_en !== 1'b0) begin errors++; $display("FAIL midrst_en: got %0b want 0", cpu_en); end
        checks++; if (step_done !== 1'b0) begin errors++; $display("FAIL midrst_done: got %0b want 0", step_done); end
        checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready: got %0b want 1", bus.cmd_ready); end
        @(negedge clk);
        reset = 1'b0;
        tick();
        tick();
        checks++; if (div_cur !== 8'd6) begin errors++; $display("FAIL midrst_pending_dropped: got %0d want 6", div_cur); end
    endtask

    task automatic model_reset;
        m_mode = 0; m_wait = 0; m_ratio = 6; m_pend = 0; m_pend_v = 0; m_rem = 0; m_count = 0;
    endtask

    // Advance the model by one clock using the inputs currently on the bus.
    task automatic model_step;
        int  op, steps, cfg_eff, nm;
        bit  pulse, acc, cmd_restart, apply;
        pulse   = (m_mode == 1 || m_mode == 2) && m_wait == 1;
        acc     = bus.cmd_valid && m_mode != 3;
        op      = int'(bus.cmd_op);
        steps   = int'(bus.cmd_steps);
        cfg_eff = (bus.cfg_div == 0) ? 1 : int'(bus.cfg_div);
        cmd_restart = acc && ((m_mode == 0 && (op == 1 || op == 2)) || op == 2);
        apply   = (m_mode == 0) || pulse || cmd_restart;
        if (apply) begin
            if (bus.cfg_valid) m_ratio = cfg_eff;
            else if (m_pend_v != 0) m_ratio = m_pend;
            m_pend_v = 0;
        end else if (bus.cfg_valid) begin
            m_pend = cfg_eff;
            m_pend_v = 1;
        end
        nm = m_mode;
        case (m_mode)
            0, 1: begin
                if (acc && op == 1) nm = 1;
                else if (acc && op == 0) nm = 0;
                else if (acc && op == 2) begin nm = (steps > 0) ? 2 : 3; m_rem = steps; end
            end
            2: begin
                if (acc && op == 0) nm = 0;
                else if (acc && op == 1) nm = 1;
                else if (acc && op == 2) begin nm = (steps > 0) ? 2 : 3; m_rem = steps; end
                else if (pulse) begin
                    if (m_rem == 1) nm = 3;
                    m_rem = m_rem - 1;
                end
            end
            default: nm = 0;
        endcase
        if (nm == 1 || nm == 2)
            m_wait = (cmd_restart || pulse) ? m_ratio : m_wait - 1;
        else
            m_wait = 0;
        if (pulse) m_count++;
        m_mode = nm;
    endtask

    task automatic test_random;
        do_reset();
        model_reset();
        for (int n = 0; n < 3000; n++) begin
            logic ee;
            ee = (m_mode == 1 || m_mode == 2) && m_wait == 1;
            checks++; if (cpu_en !== ee) begin errors++; $display("FAIL rand_en n%0d: got %0b want %0b", n, cpu_en, ee); end
            checks++; if (state !== 2'(m_mode)) begin errors++; $display("FAIL rand_state n%0d: got %0d want %0d", n, state, m_mode); end
            checks++; if (step_done !== 1'(m_mode == 3)) begin errors++; $display("FAIL rand_done n%0d: got %0b want %0b", n, step_done, (m_mode == 3)); end
            checks++; if (bus.cmd_ready !== 1'(m_mode != 3)) begin errors++; $display("FAIL rand_ready n%0d: got %0b want %0b", n, bus.cmd_ready, (m_mode != 3)); end
            checks++; if (div_cur !== DIV_W'(m_ratio)) begin errors++; $display("FAIL rand_div_cur n%0d: got %0d want %0d", n, div_cur, m_ratio); end
            checks++; if (en_count !== CNT_W'(m_count)) begin errors++; $display("FAIL rand_count n%0d: got %0d want %0d", n, en_count, m_count); end
            bus.cmd_valid = ($urandom_range(0, 5) == 0);
            bus.cmd_op    = 2'($urandom_range(0, 3));
            bus.cmd_steps = STEP_W'($urandom_range(0, 4));
            bus.cfg_valid = ($urandom_range(0, 11) == 0);
            bus.cfg_div   = DIV_W'($urandom_range(0, 5));
            reset         = ($urandom_range(0, 249) == 0);
            if (reset) model_reset();
            else       model_step();
            tick();
        end
        reset = 1'b0;
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        test_reset();
        test_run_default();
        test_step_div3();
        test_ratio_change();
        test_div_zero();
        test_step_zero();
        test_step_halt();
        test_reset_mid_step();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog: run exceeded time limit, got timeout want completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "time limit exceeded");
    end

endmodule

// File: doc/cpu_clk_en_ctrl.md
Name: cpu_clk_en_ctrl

Overview:
Clock-enable scheduler for the processor core. It replaces divided-clock generation with a single-cycle enable pulse, cpu_en, asserted once every DIV cycles of clk. A debug/host command port selects the mode: HALT, free RUN, or STEP for N enable pulses. The divide ratio is reprogrammable at runtime. New ratios take effect only at period boundaries, so the core never sees a truncated period.

Parameters:
DIV_W, 8, width of the divide ratio.
DIV_DEFAULT, 6, divide ratio loaded at reset (1..2^DIV_W-1).
STEP_W, 16, width of the step count.
CNT_W, 32, width of the issued-enable counter.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
cmd_valid  in  1  command request
cmd_ready  out  1  command accepted when cmd_valid && cmd_ready at a rising edge
cmd_op  in  2  00 HALT, 01 RUN, 10 STEP, 11 reserved (accepted, no-op)
cmd_steps  in  STEP_W  enable pulses to issue for STEP
cfg_valid  in  1  single-cycle write strobe for the divide ratio (no ready; always accepted)
cfg_div  in  DIV_W  new divide ratio; 0 treated as 1
cpu_en  out  1  core clock enable, one clk wide per period
state  out  2  00 HALT, 01 RUN, 10 STEP, 11 DONE
step_done  out  1  one-cycle pulse when a STEP sequence completes
div_cur  out  DIV_W  ratio currently in force
en_count  out  CNT_W  total cpu_en pulses since reset; wraps modulo 2^CNT_W

Behaviour:
- Reset values: state=HALT, div_cnt=0, div_q=DIV_DEFAULT, no pending ratio, remaining=0, cpu_en=0, step_done=0, en_count=0, cmd_ready=1, div_cur=DIV_DEFAULT.
- Reset is asynchronous. Reset mid-RUN or mid-STEP aborts immediately with no step_done, and a pending ratio is discarded.
- cpu_en = (state==RUN || state==STEP) && (div_cnt == div_q-1). It is combinational from registers. div_cnt advances 0..div_q-1 and wraps to 0 on the cpu_en edge.
- In HALT and DONE, div_cnt is held at 0 and cpu_en is 0.
- Latency: after the accept edge of RUN or STEP from HALT, div_cnt=0. The first cpu_en occurs in the div_q-th cycle after that edge. With div_q=1, cpu_en is high every cycle starting in the first cycle after the accept edge.
- Ratio handling: a cfg_valid strobe writes the pending register; last write wins.
  - The pending ratio is applied at any edge where div_cnt is loaded with 0: while in HALT, on a cpu_en edge, or on accepting RUN/STEP from HALT or STEP from any state.
  - A cfg_valid in the same cycle as an applying edge is applied at that edge directly.
  - div_cur always reflects div_q.
- cmd_ready = (state != DONE).
- HALT state transitions:
  - RUN -> RUN.
  - STEP with cmd_steps>0 -> STEP, remaining=cmd_steps.
  - STEP with cmd_steps=0 -> DONE, no pulses issued.
  - HALT or 11 -> stays in HALT.
- RUN state transitions:
  - HALT -> HALT, div_cnt cleared. A cpu_en in the accept cycle still counts.
  - STEP -> STEP with reload and div_cnt cleared.
  - RUN or 11 -> no effect; the period is not restarted.
- STEP state transitions:
  - On cpu_en, remaining decrements. When cpu_en is high and remaining==1 -> DONE.
  - HALT -> HALT, no step_done.
  - RUN -> RUN, div_cnt kept.
  - STEP -> reload remaining, div_cnt cleared.
  - An accepted command has priority over the decrement or DONE transition in the same cycle. The cpu_en in that cycle still counts in en_count.
- DONE: step_done=1 for exactly one cycle, cmd_ready=0, then HALT unconditionally.
- en_count increments on every cycle with cpu_en=1 and wraps from all-ones to 0.

Decomposition:
- Shared package cpu_ctrl_pkg holds:
  - the state encoding (HALT/RUN/STEP/DONE)
  - the op codes (OP_HALT/OP_RUN/OP_STEP)
  - DIV_DEFAULT
- One sub-module, clk_en_prescaler, contains div_cnt, div_q, the pending ratio register, the apply logic and cpu_en generation. It has inputs active, restart and cfg, and outputs en and div_cur.
- The FSM, step counter and en_count live in the top level.

Test Plan:
- Reset, then RUN with default ratio 6 -> cpu_en high in cycles 6, 12, 18 after accept, exactly 1 cycle wide; en_count=3 after cycle 18.
- In HALT, cfg_div=3, then STEP cmd_steps=4 -> 4 pulses spaced 3 cycles apart; step_done one cycle after the 4th pulse, then state=HALT and cmd_ready back to 1.
- RUN at ratio 6, cfg_div=2 strobed at div_cnt=2 -> the current period still ends 6 cycles after the previous pulse; subsequent pulses are every 2 cycles; div_cur changes on that edge.
- cfg_div=0, RUN -> cpu_en high every cycle, div_cur=1.
- STEP cmd_steps=0 -> DONE for one cycle with step_done=1 and no cpu_en. Also: STEP 5 with HALT issued after 2 pulses -> stops with no step_done, en_count=2.
- Reset asserted mid-STEP -> state=HALT, div_cur=6, en_count=0, outputs at reset values in the same cycle; a cfg_div=4 pending before reset is not applied.
